mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one shift-add multiplier (start/ready/word0/word1/product interface) among `num_req` requesters. It latches the granted requester's operands, pulses the multiplier start, and tracks the multiplier's ready handshake through completion. It then returns the registered product with a one-cycle done strobe to the granted requester. Zero operands bypass the multiplier, and a watchdog recovers from a multiplier that never answers.

---
 rtl/mult_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mult_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one start/ready shift-add multiplier among num_req requesters.
// Zero operands bypass the multiplier; a watchdog completes jobs whose multiplier never answers.
module mult_arbiter #(
  parameter int word_length = 4,
  parameter int num_req     = 4,
  parameter int timeout     = 4*word_length+8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [num_req-1:0]             req,
  input  logic [num_req*word_length-1:0] req_word0,
  input  logic [num_req*word_length-1:0] req_word1,
  output logic [num_req-1:0]             grant,
  output logic [num_req-1:0]             done,
  output logic [2*word_length-1:0]       result,
  output logic                           err,
  output logic                           busy,
  output logic                           mul_start,
  output logic [word_length-1:0]         mul_word0,
  output logic [word_length-1:0]         mul_word1,
  input  logic                           mul_ready,
  input  logic [2*word_length-1:0]       mul_product
);

  localparam int IW = (num_req > 1) ? $clog2(num_req) : 1;
  localparam int CW = $clog2(timeout + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, DONE} state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [IW-1:0]            gidx_q, gidx_d;
  logic [CW-1:0]            wdog_q, wdog_d;
  logic [num_req-1:0]       grant_q, grant_d;
  logic [num_req-1:0]       done_q, done_d;
  logic [2*word_length-1:0] result_q, result_d;
  logic                     err_q, err_d;
  logic                     busy_q, busy_d;
  logic                     mul_start_q, mul_start_d;
  logic [word_length-1:0]   word0_q, word0_d;
  logic [word_length-1:0]   word1_q, word1_d;

  logic [word_length-1:0]   w0_arr [num_req];
  logic [word_length-1:0]   w1_arr [num_req];
  logic                     win_found;
  logic [IW-1:0]            win_idx;
  logic [IW:0]              cand;
  logic                     launch;
  logic                     operand_zero;
  logic                     wdog_expire;

  // Scan upward from ptr, wrapping, for the first requester that is asking.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < num_req; i++) begin
      w0_arr[i] = req_word0[i*word_length +: word_length];
      w1_arr[i] = req_word1[i*word_length +: word_length];
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(num_req)) cand = cand - (IW+1)'(num_req);
      if (!win_found && req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  assign launch       = win_found && mul_ready;
  assign operand_zero = (word0_q == '0) || (word1_q == '0);
  assign wdog_expire  = (wdog_q == CW'(timeout - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      wdog_q      <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      mul_start_q <= 1'b0;
      word0_q     <= '0;
      word1_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      wdog_q      <= wdog_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      result_q    <= result_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      mul_start_q <= mul_start_d;
      word0_q     <= word0_d;
      word1_q     <= word1_d;
    end
  end

  // In WAIT_DONE a real completion takes precedence over a coincident watchdog expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (launch) state_d = LAUNCH;
      LAUNCH:    state_d = operand_zero ? DONE : WAIT_BUSY;
      WAIT_BUSY: begin
        if (!mul_ready)       state_d = WAIT_DONE;
        else if (wdog_expire) state_d = DONE;
      end
      WAIT_DONE: if (mul_ready || wdog_expire) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    wdog_d      = wdog_q;
    grant_d     = grant_q;
    done_d      = '0;
    result_d    = result_q;
    err_d       = 1'b0;
    mul_start_d = 1'b0;
    word0_d     = word0_q;
    word1_d     = word1_q;
    busy_d      = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          grant_d     = num_req'(1) << win_idx;
          gidx_d      = win_idx;
          word0_d     = w0_arr[win_idx];
          word1_d     = w1_arr[win_idx];
          mul_start_d = (w0_arr[win_idx] != '0) && (w1_arr[win_idx] != '0);
        end
      end
      LAUNCH: begin
        wdog_d = '0;
        if (operand_zero) begin
          result_d = '0;
          done_d   = grant_q;
        end
      end
      WAIT_BUSY: begin
        wdog_d = wdog_q + CW'(1);
        if (mul_ready && wdog_expire) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = grant_q;
        end
      end
      WAIT_DONE: begin
        wdog_d = wdog_q + CW'(1);
        if (mul_ready) begin
          result_d = mul_product;
          done_d   = grant_q;
        end else if (wdog_expire) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = grant_q;
        end
      end
      DONE: begin
        grant_d = '0;
        ptr_d   = (gidx_q == IW'(num_req - 1)) ? '0 : gidx_q + IW'(1);
      end
      default: ;
    endcase
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign result    = result_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mul_start = mul_start_q;
  assign mul_word0 = word0_q;
  assign mul_word1 = word1_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: a behavioural multiplier stub plus a job-level
// round-robin reference model (winner, product, completion latency, watchdog).
module tb_mult_arbiter;
  localparam int W  = 4;
  localparam int N  = 4;
  localparam int TO = 4*W + 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_word0, req_word1;
  logic [N-1:0]     grant, done;
  logic [2*W-1:0]   result;
  logic             err, busy, mul_start;
  logic [W-1:0]     mul_word0, mul_word1;
  logic             mul_ready;
  logic [2*W-1:0]   mul_product;

  mult_arbiter #(.word_length(W), .num_req(N), .timeout(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_word0(req_word0), .req_word1(req_word1),
    .grant(grant), .done(done), .result(result), .err(err), .busy(busy),
    .mul_start(mul_start), .mul_word0(mul_word0), .mul_word1(mul_word1),
    .mul_ready(mul_ready), .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ptr_m = 0;
  int op0 [N];
  int op1 [N];
  int stub_lat = 3;
  bit stub_stuck = 1'b0;
  bit s_busy = 1'b0;
  int s_cnt = 0;

  // Multiplier stub: drops ready for stub_lat cycles after a start, or never drops it when stuck.
  initial begin
    mul_ready   = 1'b1;
    mul_product = '0;
    forever begin
      @(posedge clk);
      #1;
      if (stub_stuck) begin
        s_busy      = 1'b0;
        mul_ready   = 1'b1;
        mul_product = 8'hA5;
      end else if (s_busy) begin
        if (s_cnt == 0) begin
          mul_ready   = 1'b1;
          mul_product = (2*W)'(mul_word0) * (2*W)'(mul_word1);
          s_busy      = 1'b0;
        end else begin
          s_cnt--;
        end
      end else if (mul_start) begin
        mul_ready = 1'b0;
        s_cnt     = stub_lat - 1;
        s_busy    = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] mask);
    req = mask;
    for (int i = 0; i < N; i++) begin
      req_word0[i*W +: W] = W'(op0[i]);
      req_word1[i*W +: W] = W'(op1[i]);
    end
  endtask

  function automatic int pickWinner(input logic [N-1:0] mask, input int p);
    for (int k = 0; k < N; k++)
      if (mask[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // One full job starting from an IDLE cycle with req already applied.
  task automatic runJob(input string tag, input bit disturb);
    int w, exp_res, exp_lat, n;
    bit exp_err, exp_start;
    w = pickWinner(req, ptr_m);
    if (op0[w] == 0 || op1[w] == 0) begin
      exp_res = 0; exp_lat = 1; exp_err = 1'b0; exp_start = 1'b0;
    end else if (stub_stuck) begin
      exp_res = 0; exp_lat = TO + 1; exp_err = 1'b1; exp_start = 1'b1;
    end else begin
      exp_res = op0[w] * op1[w]; exp_lat = stub_lat + 1; exp_err = 1'b0; exp_start = 1'b1;
    end
    tick();
    checkOutput({tag, " grant"}, 32'(grant), 32'(1) << w);
    checkOutput({tag, " busy"}, 32'(busy), 32'd1);
    checkOutput({tag, " mul_start"}, 32'(mul_start), 32'(exp_start));
    checkOutput({tag, " word0"}, 32'(mul_word0), 32'(op0[w]));
    checkOutput({tag, " word1"}, 32'(mul_word1), 32'(op1[w]));
    if (disturb) begin
      req[w] = 1'b0;
      req_word0[w*W +: W] = ~W'(op0[w]);
      req_word1[w*W +: W] = ~W'(op1[w]);
    end
    n = 0;
    while (done == '0 && n < 100) begin
      tick();
      n++;
    end
    checkOutput({tag, " latency"}, 32'(n), 32'(exp_lat));
    checkOutput({tag, " done"}, 32'(done), 32'(1) << w);
    checkOutput({tag, " result"}, 32'(result), 32'(exp_res));
    checkOutput({tag, " err"}, 32'(err), 32'(exp_err));
    checkOutput({tag, " grant_held"}, 32'(grant), 32'(1) << w);
    checkOutput({tag, " word0_stable"}, 32'(mul_word0), 32'(op0[w]));
    ptr_m = (w + 1) % N;
    tick();
    checkOutput({tag, " done_clear"}, 32'(done), 32'd0);
    checkOutput({tag, " grant_clear"}, 32'(grant), 32'd0);
    checkOutput({tag, " idle"}, 32'(busy), 32'd0);
    checkOutput({tag, " result_hold"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    int n;
    bit any_done;
    reset = 1'b0;
    req = '0; req_word0 = '0; req_word1 = '0;
    repeat (3) tick();
    checkOutput("rst grant", 32'(grant), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst result", 32'(result), 32'd0);
    checkOutput("rst err", 32'(err), 32'd0);
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst mul_start", 32'(mul_start), 32'd0);
    checkOutput("rst word0", 32'(mul_word0), 32'd0);
    checkOutput("rst word1", 32'(mul_word1), 32'd0);
    reset = 1'b1;
    tick();

    op0 = '{2, 4, 6, 15};
    op1 = '{3, 5, 7, 15};
    stub_lat = 3;
    applyStimulus(4'b1111);
    repeat (5) runJob("rr", 1'b0);

    op0[0] = 3; op1[0] = 5; stub_lat = 2;
    applyStimulus(4'b0001);
    runJob("single", 1'b0);

    op0[2] = 0; op1[2] = 9;
    applyStimulus(4'b0100);
    runJob("zero", 1'b0);

    stub_stuck = 1'b1;
    op0[0] = 5; op1[0] = 3;
    applyStimulus(4'b0001);
    runJob("wdog", 1'b0);
    stub_stuck = 1'b0;

    op0[0] = 1; op1[0] = 1; op0[1] = 2; op1[1] = 2;
    applyStimulus(4'b0011);
    runJob("after_wdog", 1'b0);

    op0[0] = 7; op1[0] = 9; stub_lat = 8;
    applyStimulus(4'b0001);
    tick();
    checkOutput("midrst grant", 32'(grant), 32'd1);
    repeat (3) tick();
    checkOutput("midrst waiting", 32'(mul_ready), 32'd0);
    #2;
    reset = 1'b0;
    req = '0;
    #1;
    checkOutput("midrst grant0", 32'(grant), 32'd0);
    checkOutput("midrst busy0", 32'(busy), 32'd0);
    checkOutput("midrst result0", 32'(result), 32'd0);
    checkOutput("midrst word0", 32'(mul_word0), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    ptr_m = 0;
    any_done = 1'b0;
    repeat (12) begin
      tick();
      if (done != '0) any_done = 1'b1;
    end
    checkOutput("midrst no_done", 32'(any_done), 32'd0);
    n = 0;
    while (!mul_ready && n < 50) begin
      tick();
      n++;
    end
    checkOutput("midrst stub_idle", 32'(mul_ready), 32'd1);
    applyStimulus(4'b0001);
    runJob("rearm", 1'b0);

    for (int j = 0; j < 20; j++) begin
      for (int i = 0; i < N; i++) begin
        op0[i] = $urandom_range(0, 15);
        op1[i] = $urandom_range(0, 15);
      end
      stub_lat   = $urandom_range(1, 6);
      stub_stuck = ($urandom_range(0, 7) == 0);
      applyStimulus(N'($urandom_range(1, 15)));
      runJob("rand", 1'($urandom_range(0, 1)));
      stub_stuck = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: observed no finish, expected finish before 500000");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
